// File: rtl/bp_pkg.sv
// Shared helpers for the gshare predictor: counter init value, saturating
// update functions and the PC/history index hash.
package bp_pkg;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int unsigned ctr_init(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned ctr_w);
        int unsigned max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    // Word-aligned PC bits XOR the history, history sitting in the low bits.
    function automatic int unsigned gshare_idx(input logic [63:0] pc,
                                               input logic [63:0] ghr,
                                               input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'(((pc >> 2) ^ ghr) & mask);
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Table of saturating counters: one asynchronous read port and one
// synchronous saturating-update write port.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [CTR_W-1:0] ctr [DEPTH];

    // Read returns the value held before any same-cycle update.
    assign rd_ctr = ctr[rd_idx];

    // NOTE: the table is a flop array rather than an SRAM so it can be reset;
    // predictions right after reset must see the weakly not-taken value.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_W'(ctr_init(CTR_W));
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                ctr[wr_idx] <= CTR_W'(sat_inc(32'(ctr[wr_idx]), CTR_W));
            end else begin
                ctr[wr_idx] <= CTR_W'(sat_dec(32'(ctr[wr_idx])));
            end
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare branch predictor: speculative global history, registered
// prediction outputs and mispredict-driven history recovery.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int HIST_W = 3,
    parameter int IDX_W  = 3,
    parameter int CTR_W  = 2,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pred_req,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              res_valid,
    input  logic [IDX_W-1:0]  res_idx,
    input  logic [HIST_W-1:0] res_ghr,
    input  logic              res_taken,
    input  logic              res_mispredict,
    output logic [HIST_W-1:0] ghr_out
);

    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_next;
    logic [IDX_W-1:0]  idx;
    logic [CTR_W-1:0]  rd_ctr;
    logic              taken;
    logic              recover;
    logic              accept;

    assign idx     = IDX_W'(gshare_idx(64'(pred_pc), 64'(ghr), IDX_W));
    assign taken   = rd_ctr[CTR_W-1];
    assign recover = res_valid & res_mispredict;
    assign accept  = pred_req & ~recover;
    assign ghr_out = ghr;

    bp_sat_counter_table #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (res_valid),
        .wr_idx   (res_idx),
        .wr_taken (res_taken)
    );

    // Truncating the concatenation keeps the newest HIST_W bits and also
    // covers HIST_W == 1 without a negative slice.
    // NOTE: ghr_next is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        ghr_next = ghr;
        if (recover) begin
            ghr_next = HIST_W'({res_ghr, res_taken});
        end else if (pred_req) begin
            ghr_next = HIST_W'({ghr, taken});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    // pred_taken/idx/ghr hold between requests; only pred_valid drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= accept;
            if (accept) begin
                pred_taken <= taken;
                pred_idx   <= idx;
                pred_ghr   <= ghr;
            end
        end
    end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
Parametrised successor to the 8-entry 1-bit pattern history table: a gshare predictor with N-bit saturating counters, an internal speculative global history register, and mispredict recovery. It sits in the fetch stage and returns one registered prediction per request. The execute stage resolves branches later; it carries back the index and history snapshot captured at prediction time.

Parameters:
HIST_W, 3, global history length in bits (1 <= HIST_W <= IDX_W)
IDX_W, 3, counter table index width; table depth = 2**IDX_W
CTR_W, 2, saturating counter width (>= 1)
PC_W, 32, fetch PC width (>= IDX_W+2)

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
pred_req  in  1  request prediction for pred_pc this cycle
pred_pc  in  PC_W  PC of branch being fetched
pred_valid  out  1  registered: prediction presented this cycle
pred_taken  out  1  registered: MSB of selected counter
pred_idx  out  IDX_W  registered: table index used (for resolve)
pred_ghr  out  HIST_W  registered: GHR value before speculative shift (checkpoint)
res_valid  in  1  branch resolution strobe
res_idx  in  IDX_W  index returned from pred_idx
res_ghr  in  HIST_W  checkpoint returned from pred_ghr
res_taken  in  1  actual branch outcome
res_mispredict  in  1  qualifies res_valid; outcome differed from prediction
ghr_out  out  HIST_W  current speculative GHR (debug)

Behaviour:
- Reset (reset_n=0, async, immediate): all counters = 2**(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2); GHR=0; pred_valid=0, pred_taken=0, pred_idx=0, pred_ghr=0.
- Index = pred_pc[IDX_W+1:2] XOR zero-extended GHR (GHR in low bits).
- Latency 1: pred_req at cycle N -> pred_valid=1 with outputs at cycle N+1. Without pred_req, pred_valid=0 next cycle; other outputs hold their last values.
- Speculative history: on an accepted pred_req, GHR <= {GHR[HIST_W-2:0], predicted_taken}. For HIST_W=1, GHR <= predicted_taken.
- Resolve (res_valid=1): counter[res_idx] increments if res_taken, else decrements. It saturates at 2**CTR_W-1 and at 0, with no wrap.
- Mispredict (res_valid & res_mispredict): GHR <= {res_ghr[HIST_W-2:0], res_taken}. This overrides any same-cycle speculative shift. A same-cycle pred_req is dropped: pred_valid=0 next cycle, no GHR shift from it.
- res_mispredict without res_valid is ignored.
- Same-cycle pred_req and resolve to the same index: prediction reads the pre-update counter value (read-old, no bypass). The update is still applied.
- Exactly one counter write per cycle maximum; no request backpressure, pred_req is always accepted unless dropped by a mispredict.
- Reset asserted mid-stream: in-flight prediction is lost and the table reinitialises. Resolves arriving after reset release are applied normally to the reinitialised table.

Decomposition:
- Shared package bp_pkg:
  - counter init constant function (weakly not-taken for a given CTR_W)
  - sat_inc / sat_dec functions
  - gshare index function (pc, ghr)
- Sub-module bp_sat_counter_table:
  - parameters IDX_W, CTR_W
  - one async-read port, one sync write port with saturating update, async active-low reset
- Top level holds the GHR, the index XOR, the output registers and the mispredict/drop logic.

Test Plan:
1. Reset, then pred_req pc=0x0 -> next cycle pred_valid=1, pred_taken=0, pred_idx=0, pred_ghr=0; ghr_out=000.
2. Resolve idx=5 taken twice (no mispredict), then pred_req pc=0x14 with GHR=000 -> pred_idx=5, pred_taken=1; counter[5]=11. A third taken leaves it at 11 (saturation).
3. Resolve idx=2 not-taken twice from reset -> counter[2]=00, not wrapped; later one taken -> 01, prediction still 0.
4. Three predictions predicted taken from GHR=000 -> ghr_out=111. Then res_valid+res_mispredict, res_ghr=001, res_taken=0 -> ghr_out=010 next cycle.
5. pred_req in the same cycle as a mispredict -> pred_valid=0 next cycle; GHR equals the recovered value only.
6. pred_req and resolve to the same index in one cycle, counter=01, res_taken=1 -> pred_taken=0 (old value); the next request to that index -> pred_taken=1. Assert reset_n low mid-sequence -> outputs 0 immediately, counters back to 01.
